// File: rtl/ctrl_pkg.sv
// Shared control-path types: opcodes, field encodings and the stage control words.
package ctrl_pkg;

  localparam logic [6:0] OP_LUI   = 7'd55;
  localparam logic [6:0] OP_R     = 7'd51;
  localparam logic [6:0] OP_I     = 7'd19;
  localparam logic [6:0] OP_B     = 7'd99;
  localparam logic [6:0] OP_JAL   = 7'd111;
  localparam logic [6:0] OP_JALR  = 7'd103;
  localparam logic [6:0] OP_LOAD  = 7'd3;
  localparam logic [6:0] OP_STORE = 7'd35;

  typedef enum logic [2:0] {
    IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10
  } res_src_e;

  typedef enum logic [2:0] {
    MEM_LW = 3'b000, MEM_SW = 3'b001, MEM_LB = 3'b010, MEM_SB = 3'b011, MEM_LBU = 3'b110
  } mem_ctrl_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000, ALU_SLL = 4'b0001, ALU_SLT = 4'b0010, ALU_XOR = 4'b0100,
    ALU_SRL = 4'b0101, ALU_OR  = 4'b0110, ALU_AND = 4'b0111, ALU_SUB = 4'b1000,
    ALU_SRA = 4'b1101
  } alu_op_e;

  // Fields carried through E and M
  typedef struct packed {
    logic      valid;
    logic      illegal;
    logic      reg_write;
    res_src_e  result_src;
    mem_ctrl_e mem_ctrl;
  } stage_t;

  // W drops MemCtrl: memory access is finished by then
  typedef struct packed {
    logic     valid;
    logic     illegal;
    logic     reg_write;
    res_src_e result_src;
  } wb_t;

  typedef struct packed {
    stage_t     s;
    logic [3:0] alu;
    logic       alu_src;
    logic       branch;
    logic       bne;
    logic       jump;
    logic       jalr;
  } ctrl_word_t;

endpackage

// File: rtl/control_decode.sv
// Combinational RV32I decode of opcode/funct3/funct7 into a control word.
module control_decode
  import ctrl_pkg::*;
#(
  parameter int FULL_ALU = 0
) (
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  output ctrl_word_t cw,
  output imm_src_e   imm_src
);

  localparam logic FULL = (FULL_ALU != 0);

  logic legal;

  always_comb begin
    cw      = '0;
    imm_src = IMM_I;
    legal   = 1'b0;
    case (op)
      OP_LUI: begin
        legal = 1'b1; cw.s.reg_write = 1'b1; cw.alu_src = 1'b1; imm_src = IMM_U;
      end
      OP_R: begin
        cw.s.reg_write = 1'b1;
        cw.alu = {FULL & funct7, funct3};
        if (funct7) legal = FULL && (funct3 == 3'b000 || funct3 == 3'b101);
        else        legal = (funct3 inside {3'b000, 3'b001, 3'b100, 3'b101, 3'b111}) ||
                            (FULL && (funct3 inside {3'b010, 3'b110}));
      end
      OP_I: begin
        // funct7 is an immediate bit here except for the SRLI/SRAI split
        cw.s.reg_write = 1'b1; cw.alu_src = 1'b1;
        cw.alu = {FULL & funct7 & (funct3 == 3'b101), funct3};
        legal  = (funct3 == 3'b000) ||
                 (FULL && ((funct3 inside {3'b100, 3'b101, 3'b110, 3'b111}) ||
                           (funct3 == 3'b001 && !funct7)));
      end
      OP_B: begin
        // equality via XOR so the zero flag works with the base ALU
        legal = (funct3[2:1] == 2'b00); cw.branch = 1'b1; cw.bne = funct3[0];
        cw.alu = ALU_XOR; imm_src = IMM_B;
      end
      OP_JAL: begin
        legal = 1'b1; cw.jump = 1'b1; imm_src = IMM_J;
        cw.s.result_src = RES_PC4; cw.s.reg_write = 1'b1;
      end
      OP_JALR: begin
        legal = 1'b1; cw.jalr = 1'b1; cw.alu_src = 1'b1;
        cw.s.result_src = RES_PC4; cw.s.reg_write = 1'b1;
      end
      OP_LOAD: begin
        cw.s.reg_write = 1'b1; cw.s.result_src = RES_MEM; cw.alu_src = 1'b1;
        case (funct3)
          3'b010:  begin legal = 1'b1; cw.s.mem_ctrl = MEM_LW;  end
          3'b000:  begin legal = 1'b1; cw.s.mem_ctrl = MEM_LB;  end
          3'b100:  begin legal = 1'b1; cw.s.mem_ctrl = MEM_LBU; end
          default: legal = 1'b0;
        endcase
      end
      OP_STORE: begin
        imm_src = IMM_S; cw.alu_src = 1'b1;
        case (funct3)
          3'b010:  begin legal = 1'b1; cw.s.mem_ctrl = MEM_SW; end
          3'b000:  begin legal = 1'b1; cw.s.mem_ctrl = MEM_SB; end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      cw      = '0;
      imm_src = IMM_I;
    end
    cw.s.valid   = 1'b1;
    cw.s.illegal = ~legal;
  end

endmodule

// File: rtl/control_pipeline.sv
// Control word pipeline D->E->M->W with bubble insertion, PC select and error tracking.
module control_pipeline
  import ctrl_pkg::*;
#(
  parameter int FULL_ALU = 0,
  parameter int ALU_W    = 3 + FULL_ALU
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7,
  input  logic             FlushE,
  input  logic             ZeroE,
  output logic [2:0]       ImmSrcD,
  output logic             IllegalD,
  output logic             RegWriteE,
  output logic             RegWriteM,
  output logic             RegWriteW,
  output logic [1:0]       ResultSrcE,
  output logic [1:0]       ResultSrcM,
  output logic [1:0]       ResultSrcW,
  output logic [2:0]       MemCtrlM,
  output logic [ALU_W-1:0] ALUControlE,
  output logic             ALUSrcE,
  output logic [1:0]       PCSrcE,
  output logic             RetireW,
  output logic             ErrorW
);

  ctrl_word_t cw_d, e_q;
  imm_src_e   imm_src_d;
  stage_t     m_q;
  wb_t        w_q;
  logic       error_q;
  logic       unused_alu;

  control_decode #(.FULL_ALU(FULL_ALU)) u_decode (
    .op      (op),
    .funct3  (funct3),
    .funct7  (funct7),
    .cw      (cw_d),
    .imm_src (imm_src_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q     <= '0;
      m_q     <= '0;
      w_q     <= '0;
      error_q <= 1'b0;
    end else begin
      e_q            <= FlushE ? '0 : cw_d;
      m_q            <= e_q.s;
      w_q.valid      <= m_q.valid;
      w_q.illegal    <= m_q.illegal;
      w_q.reg_write  <= m_q.reg_write;
      w_q.result_src <= m_q.result_src;
      error_q        <= error_q | (w_q.valid & w_q.illegal);
    end
  end

  // Resolved from E state only, so a concurrent FlushE does not cancel it
  always_comb begin
    PCSrcE = 2'b00;
    if (e_q.jalr)                                          PCSrcE = 2'b10;
    else if (e_q.jump | (e_q.branch & (ZeroE ^ e_q.bne)))  PCSrcE = 2'b01;
  end

  assign ImmSrcD     = imm_src_d;
  assign IllegalD    = cw_d.s.illegal;
  assign RegWriteE   = e_q.s.reg_write;
  assign ResultSrcE  = e_q.s.result_src;
  assign ALUControlE = e_q.alu[ALU_W-1:0];
  assign ALUSrcE     = e_q.alu_src;
  assign RegWriteM   = m_q.reg_write;
  assign ResultSrcM  = m_q.result_src;
  assign MemCtrlM    = m_q.mem_ctrl;
  assign RegWriteW   = w_q.reg_write;
  assign ResultSrcW  = w_q.result_src;
  assign RetireW     = w_q.valid & ~w_q.illegal;
  assign ErrorW      = error_q | (w_q.valid & w_q.illegal);
  assign unused_alu  = ^e_q.alu;

endmodule

// File: tb/tb_control_pipeline.sv
// Random + directed check of control_pipeline (both ALU variants) against a behavioural model.
module tb_control_pipeline;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'd19;
  logic [2:0] funct3 = 3'd0;
  logic       funct7 = 1'b0, FlushE = 1'b0, ZeroE = 1'b0;

  logic [2:0] imm_src [2];
  logic       illegal_d [2], rw_e [2], rw_m [2], rw_w [2], alu_src [2], retire [2], error [2];
  logic [1:0] rs_e [2], rs_m [2], rs_w [2], pcsrc [2];
  logic [2:0] mem_m [2];
  logic [2:0] alu0;
  logic [3:0] alu1;

  always #5 clk = ~clk;

  control_pipeline #(.FULL_ALU(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
    .FlushE(FlushE), .ZeroE(ZeroE), .ImmSrcD(imm_src[0]), .IllegalD(illegal_d[0]),
    .RegWriteE(rw_e[0]), .RegWriteM(rw_m[0]), .RegWriteW(rw_w[0]),
    .ResultSrcE(rs_e[0]), .ResultSrcM(rs_m[0]), .ResultSrcW(rs_w[0]),
    .MemCtrlM(mem_m[0]), .ALUControlE(alu0), .ALUSrcE(alu_src[0]),
    .PCSrcE(pcsrc[0]), .RetireW(retire[0]), .ErrorW(error[0]));

  control_pipeline #(.FULL_ALU(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
    .FlushE(FlushE), .ZeroE(ZeroE), .ImmSrcD(imm_src[1]), .IllegalD(illegal_d[1]),
    .RegWriteE(rw_e[1]), .RegWriteM(rw_m[1]), .RegWriteW(rw_w[1]),
    .ResultSrcE(rs_e[1]), .ResultSrcM(rs_m[1]), .ResultSrcW(rs_w[1]),
    .MemCtrlM(mem_m[1]), .ALUControlE(alu1), .ALUSrcE(alu_src[1]),
    .PCSrcE(pcsrc[1]), .RetireW(retire[1]), .ErrorW(error[1]));

  typedef struct {
    bit       valid, illegal, rw;
    bit [1:0] rs;
    bit [2:0] mem;
    bit [3:0] alu;
    bit       alu_src, branch, bne, jump, jalr, chk_alu, chk_imm;
    bit [2:0] imm;
  } ref_t;

  ref_t e_m [2], m_m [2], w_m [2];
  bit   err_m [2];
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic ref_t bubble();
    ref_t r = '{default: 0};
    r.chk_alu = 1'b1;
    return r;
  endfunction

  // Instruction-level legality and field tables
  function automatic ref_t ref_decode(bit [6:0] o, bit [2:0] f3, bit f7, bit full);
    ref_t r = '{default: 0};
    bit ok = 1'b0;
    bit [3:0] code = {f7, f3};
    r.valid = 1'b1; r.chk_alu = 1'b1; r.chk_imm = 1'b1;
    case (o)
      7'd55: begin ok = 1'b1; r.rw = 1'b1; r.alu_src = 1'b1; r.imm = 3'd4; end
      7'd51: begin
        ok = (code inside {4'h0, 4'h1, 4'h4, 4'h5, 4'h7}) ||
             (full && (code inside {4'h2, 4'h6, 4'h8, 4'hd}));
        r.rw = 1'b1; r.alu = full ? code : {1'b0, f3}; r.chk_imm = 1'b0;
      end
      7'd19: begin
        ok = (f3 == 3'd0) || (full && ((f3 inside {3'd4, 3'd5, 3'd6, 3'd7}) || code == 4'h1));
        r.rw = 1'b1; r.alu_src = 1'b1;
        r.alu = (full && f3 == 3'd5) ? code : {1'b0, f3};
      end
      7'd99: begin
        ok = (f3 == 3'd0 || f3 == 3'd1); r.branch = 1'b1; r.bne = (f3 == 3'd1);
        r.imm = 3'd2; r.chk_alu = 1'b0;
      end
      7'd111: begin
        ok = 1'b1; r.jump = 1'b1; r.imm = 3'd3; r.rs = 2'd2; r.rw = 1'b1; r.chk_alu = 1'b0;
      end
      7'd103: begin ok = 1'b1; r.jalr = 1'b1; r.alu_src = 1'b1; r.rs = 2'd2; r.rw = 1'b1; end
      7'd3: begin
        r.rs = 2'd1; r.rw = 1'b1; r.alu_src = 1'b1;
        if (f3 == 3'd2)      begin ok = 1'b1; r.mem = 3'b000; end
        else if (f3 == 3'd0) begin ok = 1'b1; r.mem = 3'b010; end
        else if (f3 == 3'd4) begin ok = 1'b1; r.mem = 3'b110; end
      end
      7'd35: begin
        r.imm = 3'd1; r.chk_alu = 1'b0;
        if (f3 == 3'd2)      begin ok = 1'b1; r.mem = 3'b001; end
        else if (f3 == 3'd0) begin ok = 1'b1; r.mem = 3'b011; end
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      r = '{default: 0};
      r.valid = 1'b1; r.illegal = 1'b1;
    end
    return r;
  endfunction

  task automatic reset_model();
    for (int k = 0; k < 2; k++) begin
      e_m[k] = bubble(); m_m[k] = bubble(); w_m[k] = bubble(); err_m[k] = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      ref_t d = ref_decode(op, funct3, funct7, 1'(k));
      bit [1:0] pc = e_m[k].jalr ? 2'd2 :
                     (e_m[k].jump || (e_m[k].branch && (ZeroE ^ e_m[k].bne))) ? 2'd1 : 2'd0;
      chk($sformatf("d%0d IllegalD", k), 32'(illegal_d[k]), 32'(d.illegal));
      if (d.chk_imm) chk($sformatf("d%0d ImmSrcD", k), 32'(imm_src[k]), 32'(d.imm));
      chk($sformatf("d%0d RegWriteE", k), 32'(rw_e[k]), 32'(e_m[k].rw));
      chk($sformatf("d%0d ResultSrcE", k), 32'(rs_e[k]), 32'(e_m[k].rs));
      if (e_m[k].chk_alu) begin
        chk($sformatf("d%0d ALUSrcE", k), 32'(alu_src[k]), 32'(e_m[k].alu_src));
        chk($sformatf("d%0d ALUControlE", k), (k == 1) ? 32'(alu1) : 32'(alu0), 32'(e_m[k].alu));
      end
      chk($sformatf("d%0d PCSrcE", k), 32'(pcsrc[k]), 32'(pc));
      chk($sformatf("d%0d RegWriteM", k), 32'(rw_m[k]), 32'(m_m[k].rw));
      chk($sformatf("d%0d ResultSrcM", k), 32'(rs_m[k]), 32'(m_m[k].rs));
      chk($sformatf("d%0d MemCtrlM", k), 32'(mem_m[k]), 32'(m_m[k].mem));
      chk($sformatf("d%0d RegWriteW", k), 32'(rw_w[k]), 32'(w_m[k].rw));
      chk($sformatf("d%0d ResultSrcW", k), 32'(rs_w[k]), 32'(w_m[k].rs));
      chk($sformatf("d%0d RetireW", k), 32'(retire[k]), 32'(w_m[k].valid && !w_m[k].illegal));
      chk($sformatf("d%0d ErrorW", k), 32'(error[k]),
          32'(err_m[k] || (w_m[k].valid && w_m[k].illegal)));
    end
  endtask

  // Called just after a rising edge; returns just after the next one
  task automatic step(input bit [6:0] o, input bit [2:0] f3, input bit f7,
                      input bit fl, input bit z);
    op = o; funct3 = f3; funct7 = f7; FlushE = fl; ZeroE = z;
    @(negedge clk);
    check_all();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      err_m[k] = err_m[k] || (w_m[k].valid && w_m[k].illegal);
      w_m[k] = m_m[k];
      m_m[k] = e_m[k];
      e_m[k] = FlushE ? bubble() : ref_decode(op, funct3, funct7, 1'(k));
    end
    #1;
  endtask

  task automatic rand_step();
    bit [6:0] ops [9] = '{7'd55, 7'd51, 7'd19, 7'd99, 7'd111, 7'd103, 7'd3, 7'd35, 7'd0};
    int idx = $urandom_range(0, 8);
    bit [6:0] o = (idx == 8) ? 7'($urandom) : ops[idx];
    step(o, 3'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
  endtask

  initial begin
    reset_model();
    #3 check_all();
    @(posedge clk); #1;
    check_all();
    rst_n = 1'b1;

    step(7'd51, 3'd0, 1'b0, 1'b0, 1'b0);   // ADD
    step(7'd99, 3'd1, 1'b0, 1'b0, 1'b0);   // BNE
    step(7'd99, 3'd1, 1'b0, 1'b0, 1'b0);   // BNE in E, Z=0 -> taken
    step(7'd99, 3'd0, 1'b0, 1'b0, 1'b1);   // BNE in E, Z=1 -> not taken
    step(7'd103, 3'd0, 1'b0, 1'b0, 1'b0);  // BEQ in E, Z=0 -> not taken
    step(7'd103, 3'd0, 1'b0, 1'b0, 1'b1);  // JALR in E
    step(7'd99, 3'd0, 1'b0, 1'b0, 1'b0);   // JALR in E, Z=0
    step(7'd3, 3'd2, 1'b0, 1'b1, 1'b1);    // LW flushed; BEQ in E, Z=1 -> taken
    step(7'd35, 3'd0, 1'b0, 1'b0, 1'b0);   // SB
    step(7'd51, 3'd0, 1'b1, 1'b0, 1'b0);   // SUB: illegal on base ALU
    step(7'd3, 3'd4, 1'b0, 1'b0, 1'b0);    // LBU
    step(7'd111, 3'd0, 1'b0, 1'b0, 1'b0);  // JAL
    step(7'd0, 3'd0, 1'b0, 1'b1, 1'b0);    // op 0 with flush while JAL in E
    step(7'd19, 3'd0, 1'b0, 1'b1, 1'b0);   // back-to-back flush
    for (int i = 0; i < 5; i++) step(7'd19, 3'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) rand_step();

    // Mid-stream reset with a LW in E
    step(7'd51, 3'd0, 1'b1, 1'b0, 1'b0);
    step(7'd3, 3'd2, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 reset_model();
    check_all();
    @(posedge clk); #1;
    check_all();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(7'd19, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) rand_step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
